branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline. Successor to the fixed single-mode predictor.
- Adds a tagged branch target buffer (BTB) and a pattern history table (PHT) of N-bit saturating counters.
- Selectable indexing mode: bimodal or gshare, using a global history register (GHR).
- IF looks up with the fetch PC. ID resolves the branch and sends an update. The block reports a mispredict and the corrected PC, and keeps statistics counters.

Parameters:
- ADDR_W, 32, PC/target width
- BTB_IDX, 4, log2 BTB entries (16)
- PHT_IDX, 6, log2 PHT entries (64)
- CTR_BITS, 2, saturating counter width
- HIST_BITS, 6, GHR width (must be <= PHT_IDX)
- MODE, 0, 0 = bimodal (PHT index = pc[PHT_IDX+1:2]); 1 = gshare (pc[PHT_IDX+1:2] XOR zero-extended GHR)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- if_pc  in  ADDR_W  fetch PC
- pred_taken  out  1  predict taken
- pred_target  out  ADDR_W  predicted target (valid when pred_taken)
- pred_hit  out  1  BTB tag hit
- pred_idx  out  PHT_IDX  PHT index used; pipeline carries it to ID
- upd_valid  in  1  resolution strobe (ID, one per branch)
- upd_pc  in  ADDR_W  PC of resolved branch
- upd_idx  in  PHT_IDX  pred_idx carried with that branch
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual target
- upd_pred_taken  in  1  prediction made for that branch
- upd_pred_target  in  ADDR_W  target predicted for that branch
- mispredict  out  1  flush request
- correct_pc  out  ADDR_W  redirect PC
- stat_branches  out  32  resolved-branch count
- stat_mispredicts  out  32  mispredict count

Behaviour:
- Storage: BTB entry = {valid, tag = pc[ADDR_W-1:BTB_IDX+2], target}; BTB index = pc[BTB_IDX+1:2]. PHT = 2^PHT_IDX counters.
- Lookup is combinational from flops; zero-cycle latency, same cycle as IF.
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & counter MSB.
  - pred_target = BTB target on a hit, else 0.
  - pred_idx is per MODE, using the current GHR.
- Reset: all BTB valid = 0; all counters = 2^(CTR_BITS-1)-1 (weakly not-taken, 01 for 2 bits); GHR = 0; stats = 0.
  - Takes effect in one edge. While reset is high, pred_* outputs are 0 and updates are ignored.
  - Reset mid-stream discards any in-flight update issued in the same cycle.
- Update on posedge when upd_valid:
  - PHT[upd_idx]: +1 if taken, -1 if not, saturating at 0 and 2^CTR_BITS-1.
  - BTB: if taken, write {1, tag, upd_target} at upd_pc's index. This allocates, or overwrites on conflict: direct-mapped, no replacement policy. If not taken, the BTB is unchanged.
  - GHR (MODE=1 only): GHR <= {GHR[HIST_BITS-2:0], upd_taken}. Non-speculative. MODE=0 holds GHR at 0.
  - stat_branches += 1; stat_mispredicts += mispredict. Both saturate at 2^32-1.
- Mispredict (combinational, gated by upd_valid):
  - mispredict = (upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target).
  - correct_pc = upd_taken ? upd_target : upd_pc + 4. Computed mod 2^ADDR_W; upd_pc = max wraps to 0+3.
  - When upd_valid = 0: mispredict = 0, correct_pc = 0.
- Simultaneous lookup and update to the same entry: lookup returns the pre-update value; the new value is visible the next cycle. Same for the GHR.
- Back-to-back updates every cycle are supported; each updates independently.
- upd_idx is used verbatim: no recomputation and no range check, since the width is exact.

Test Plan:
- Reset then if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_idx=0x10 (MODE 0).
- Bimodal, branch at 0x40 target 0x100, taken 2x (pred NT) -> first update mispredict=1, correct_pc=0x100; counter 01->10->11; lookup 0x40 gives pred_taken=1, pred_target=0x100; then one not-taken -> 10, still predict taken.
- Saturation: 4 not-taken updates on idx 5 -> counter 00, stays 00; 5 taken -> 11, stays 11.
- BTB conflict: taken at 0x40 then taken at 0x440 (same index, BTB_IDX=4) -> lookup 0x40 pred_hit=0, lookup 0x440 pred_hit=1.
- Gshare: outcomes T,T,N -> GHR=0b000110; lookup at 0x40 -> pred_idx = 0x10^0x06 = 0x16; same-cycle update shows old GHR on pred_idx.
- Stats and reset: 10 updates with 3 mispredicts -> stat_branches=10, stat_mispredicts=3; assert reset 1 cycle with upd_valid=1 -> stats 0, all pred_hit=0, PHT unchanged by that update.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: tagged direct-mapped BTB plus a PHT of saturating counters,
// indexed bimodally (MODE=0) or by gshare (MODE=1) with a non-speculative global history.
module branch_predictor_btb #(
    parameter int ADDR_W    = 32,
    parameter int BTB_IDX   = 4,
    parameter int PHT_IDX   = 6,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 6,
    parameter int MODE      = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   if_pc,
    output logic                pred_taken,
    output logic [ADDR_W-1:0]   pred_target,
    output logic                pred_hit,
    output logic [PHT_IDX-1:0]  pred_idx,
    input  logic                upd_valid,
    input  logic [ADDR_W-1:0]   upd_pc,
    input  logic [PHT_IDX-1:0]  upd_idx,
    input  logic                upd_taken,
    input  logic [ADDR_W-1:0]   upd_target,
    input  logic                upd_pred_taken,
    input  logic [ADDR_W-1:0]   upd_pred_target,
    output logic                mispredict,
    output logic [ADDR_W-1:0]   correct_pc,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
);

    localparam int BTB_N = 1 << BTB_IDX;
    localparam int PHT_N = 1 << PHT_IDX;
    localparam int TAG_W = ADDR_W - BTB_IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic                r_btb_valid [BTB_N];
    logic [TAG_W-1:0]    r_btb_tag   [BTB_N];
    logic [ADDR_W-1:0]   r_btb_tgt   [BTB_N];
    logic [CTR_BITS-1:0] r_pht       [PHT_N];
    logic [HIST_BITS-1:0] r_ghr;
    logic [31:0]         r_stat_br;
    logic [31:0]         r_stat_mp;

    logic [BTB_IDX-1:0]  w_lk_bidx;
    logic [TAG_W-1:0]    w_lk_tag;
    logic [PHT_IDX-1:0]  w_lk_pidx;
    logic                w_lk_hit;
    logic [BTB_IDX-1:0]  w_upd_bidx;
    logic [TAG_W-1:0]    w_upd_tag;
    logic [CTR_BITS-1:0] w_ctr;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_mp;
    logic                w_unused;

    assign w_unused   = ^if_pc[1:0];
    assign w_lk_bidx  = if_pc[BTB_IDX+1:2];
    assign w_lk_tag   = if_pc[ADDR_W-1:BTB_IDX+2];
    assign w_upd_bidx = upd_pc[BTB_IDX+1:2];
    assign w_upd_tag  = upd_pc[ADDR_W-1:BTB_IDX+2];

    always_comb begin
        w_lk_pidx = if_pc[PHT_IDX+1:2];
        if (MODE == 1)
            w_lk_pidx = if_pc[PHT_IDX+1:2] ^ PHT_IDX'(r_ghr);
    end

    assign w_lk_hit    = r_btb_valid[w_lk_bidx] && (r_btb_tag[w_lk_bidx] == w_lk_tag);
    assign pred_hit    = !reset && w_lk_hit;
    assign pred_taken  = !reset && w_lk_hit && r_pht[w_lk_pidx][CTR_BITS-1];
    assign pred_target = (!reset && w_lk_hit) ? r_btb_tgt[w_lk_bidx] : '0;
    assign pred_idx    = reset ? '0 : w_lk_pidx;

    // A taken branch that hit the predicted direction can still redirect on a wrong target.
    assign w_mp = (upd_taken != upd_pred_taken)
                | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target));
    assign mispredict = upd_valid & w_mp;
    assign correct_pc = !upd_valid ? '0
                      : (upd_taken ? upd_target : upd_pc + ADDR_W'(4));

    assign w_ctr = r_pht[upd_idx];
    always_comb begin
        w_ctr_next = w_ctr;
        if (upd_taken && (w_ctr != '1))
            w_ctr_next = w_ctr + CTR_BITS'(1);
        else if (!upd_taken && (w_ctr != '0))
            w_ctr_next = w_ctr - CTR_BITS'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTB_N; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_btb_tag[i]   <= '0;
                r_btb_tgt[i]   <= '0;
            end
            for (int unsigned i = 0; i < PHT_N; i++)
                r_pht[i] <= CTR_INIT;
            r_ghr     <= '0;
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (upd_valid) begin
            r_pht[upd_idx] <= w_ctr_next;
            if (upd_taken) begin
                r_btb_valid[w_upd_bidx] <= 1'b1;
                r_btb_tag[w_upd_bidx]   <= w_upd_tag;
                r_btb_tgt[w_upd_bidx]   <= upd_target;
            end
            if (MODE == 1)
                r_ghr <= (r_ghr << 1) | HIST_BITS'(upd_taken);
            if (r_stat_br != '1)
                r_stat_br <= r_stat_br + 32'd1;
            if (w_mp && (r_stat_mp != '1))
                r_stat_mp <= r_stat_mp + 32'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: a bimodal and a gshare instance share stimulus and are
// both compared every cycle against an arithmetic model of the prediction tables.
module tb_branch_predictor_btb;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_idx;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic [1:0]  tk;
    logic [1:0]  hit;
    logic [31:0] ptgt [2];
    logic [5:0]  pidx [2];
    logic [1:0]  mp;
    logic [31:0] cpc  [2];
    logic [31:0] sbr  [2];
    logic [31:0] smp  [2];

    int n_assert = 0;
    int n_fail   = 0;

    bit          m_v   [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_pht [64];
    int          m_ghr;
    longint      m_br, m_mp;

    always #5 clock = ~clock;

    branch_predictor_btb #(.ADDR_W(32), .BTB_IDX(4), .PHT_IDX(6), .CTR_BITS(2),
                           .HIST_BITS(6), .MODE(0)) u_bi (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .pred_taken(tk[0]), .pred_target(ptgt[0]), .pred_hit(hit[0]), .pred_idx(pidx[0]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mp[0]), .correct_pc(cpc[0]),
        .stat_branches(sbr[0]), .stat_mispredicts(smp[0]));

    branch_predictor_btb #(.ADDR_W(32), .BTB_IDX(4), .PHT_IDX(6), .CTR_BITS(2),
                           .HIST_BITS(6), .MODE(1)) u_gs (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .pred_taken(tk[1]), .pred_target(ptgt[1]), .pred_hit(hit[1]), .pred_idx(pidx[1]),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mp[1]), .correct_pc(cpc[1]),
        .stat_branches(sbr[1]), .stat_mispredicts(smp[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lk_idx(input logic [31:0] pc, input int mode);
        int base;
        base = int'((pc >> 2) % 64);
        return mode == 1 ? (base ^ m_ghr) : base;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic v, input logic [31:0] upc,
                         input logic [5:0] uidx, input logic t, input logic [31:0] ttgt,
                         input logic pt, input logic [31:0] ptg);
        if_pc = pc; upd_valid = v; upd_pc = upc; upd_idx = uidx; upd_taken = t;
        upd_target = ttgt; upd_pred_taken = pt; upd_pred_target = ptg;
    endtask

    task automatic look(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] upc, input logic t, input logic [31:0] ttgt,
                       input logic pt, input logic [31:0] ptg);
        drive(upc, 1'b1, upc, 6'((upc >> 2) % 64), t, ttgt, pt, ptg);
    endtask

    task automatic sample();
        int b, ix;
        bit e_hit, e_mp;
        logic [31:0] e_cpc;
        @(negedge clock);
        b = int'((if_pc >> 2) % 16);
        for (int m = 0; m < 2; m++) begin
            ix = lk_idx(if_pc, m);
            e_hit = !reset && m_v[b] && (m_tag[b] == (if_pc >> 6));
            chk($sformatf("pred_hit[m%0d]", m), 64'(hit[m]), 64'(e_hit));
            chk($sformatf("pred_taken[m%0d]", m), 64'(tk[m]), 64'(e_hit && m_pht[ix] >= 2));
            chk($sformatf("pred_target[m%0d]", m), 64'(ptgt[m]), e_hit ? 64'(m_tgt[b]) : 64'h0);
            chk($sformatf("pred_idx[m%0d]", m), 64'(pidx[m]), reset ? 64'h0 : 64'(ix));
            if (!reset) begin
                e_mp  = upd_valid && ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_target != upd_pred_target));
                e_cpc = !upd_valid ? 32'h0 : (upd_taken ? upd_target : upd_pc + 32'd4);
                chk($sformatf("mispredict[m%0d]", m), 64'(mp[m]), 64'(e_mp));
                chk($sformatf("correct_pc[m%0d]", m), 64'(cpc[m]), 64'(e_cpc));
            end
            chk($sformatf("stat_branches[m%0d]", m), 64'(sbr[m]), 64'(m_br));
            chk($sformatf("stat_mispredicts[m%0d]", m), 64'(smp[m]), 64'(m_mp));
        end
    endtask

    task automatic tick();
        int b, ix;
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
            for (int i = 0; i < 64; i++) m_pht[i] = 1;
            m_ghr = 0; m_br = 0; m_mp = 0;
        end else if (upd_valid) begin
            ix = int'(upd_idx);
            m_pht[ix] = upd_taken ? ((m_pht[ix] + 1 > 3) ? 3 : m_pht[ix] + 1)
                                  : ((m_pht[ix] - 1 < 0) ? 0 : m_pht[ix] - 1);
            if (upd_taken) begin
                b = int'((upd_pc >> 2) % 16);
                m_v[b] = 1'b1; m_tag[b] = upd_pc >> 6; m_tgt[b] = upd_target;
            end
            m_ghr = (m_ghr * 2 + int'(upd_taken)) % 64;
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (((upd_taken != upd_pred_taken) ||
                 (upd_taken && upd_target != upd_pred_target)) && m_mp < 64'hFFFF_FFFF) m_mp++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; look(32'h40); sample(); tick(); reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] tbl [6];
        tbl[0] = 32'h40; tbl[1] = 32'h440; tbl[2] = 32'h14;
        tbl[3] = 32'h80; tbl[4] = 32'hFFFF_FFFC; tbl[5] = $urandom & 32'hFFC;
        return tbl[$urandom_range(0, 5)];
    endfunction

    initial begin
        reset = 1'b1;
        look(32'h0);
        for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; end
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        m_ghr = 0; m_br = 0; m_mp = 0;
        do_reset();

        look(32'h40); sample();
        chk("rst_hit", 64'(hit[0]), 64'h0);
        chk("rst_taken", 64'(tk[0]), 64'h0);
        chk("rst_idx", 64'(pidx[0]), 64'h10);
        tick();

        // Bimodal training at 0x40 -> 0x100
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); sample();
        chk("bi_mp1", 64'(mp[0]), 64'h1);
        chk("bi_cpc1", 64'(cpc[0]), 64'h100);
        tick();
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); sample(); tick();
        look(32'h40); sample();
        chk("bi_taken", 64'(tk[0]), 64'h1);
        chk("bi_target", 64'(ptgt[0]), 64'h100);
        tick();
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); sample();
        chk("bi_nt_mp", 64'(mp[0]), 64'h1);
        chk("bi_nt_cpc", 64'(cpc[0]), 64'h44);
        tick();
        look(32'h40); sample();
        chk("bi_still_taken", 64'(tk[0]), 64'h1);
        tick();

        // Saturation on PHT index 5
        upd(32'h14, 1'b1, 32'h200, 1'b0, 32'h0); sample(); tick();
        for (int i = 0; i < 4; i++) begin upd(32'h14, 1'b0, 32'h0, 1'b0, 32'h0); sample(); tick(); end
        look(32'h14); sample();
        chk("sat0_taken", 64'(tk[0]), 64'h0);
        chk("sat0_hit", 64'(hit[0]), 64'h1);
        tick();
        for (int i = 0; i < 5; i++) begin upd(32'h14, 1'b1, 32'h200, 1'b1, 32'h200); sample(); tick(); end
        look(32'h14); sample();
        chk("sat3_taken", 64'(tk[0]), 64'h1);
        tick();
        for (int i = 0; i < 2; i++) begin upd(32'h14, 1'b0, 32'h0, 1'b1, 32'h200); sample(); tick(); end
        look(32'h14); sample();
        chk("sat3_down2", 64'(tk[0]), 64'h0);
        tick();

        // BTB conflict at index 0
        upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); sample(); tick();
        upd(32'h440, 1'b1, 32'h300, 1'b0, 32'h0); sample(); tick();
        look(32'h40); sample();
        chk("conf_hit_old", 64'(hit[0]), 64'h0);
        tick();
        look(32'h440); sample();
        chk("conf_hit_new", 64'(hit[0]), 64'h1);
        chk("conf_target", 64'(ptgt[0]), 64'h300);
        tick();

        // Boundaries on correct_pc and gating
        upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0); sample();
        chk("wrap_cpc", 64'(cpc[0]), 64'h0);
        chk("wrap_mp", 64'(mp[0]), 64'h0);
        tick();
        drive(32'h0, 1'b1, 32'hFFFF_FFFF, 6'h3F, 1'b0, 32'h0, 1'b0, 32'h0); sample();
        chk("wrap_cpc3", 64'(cpc[0]), 64'h3);
        tick();
        drive(32'h40, 1'b0, 32'h40, 6'h10, 1'b1, 32'h123, 1'b0, 32'h0); sample();
        chk("noval_mp", 64'(mp[0]), 64'h0);
        chk("noval_cpc", 64'(cpc[0]), 64'h0);
        tick();
        upd(32'h40, 1'b1, 32'h104, 1'b1, 32'h100); sample();
        chk("tgt_mp", 64'(mp[0]), 64'h1);
        tick();

        // Gshare history T,T,N
        do_reset();
        upd(32'h80, 1'b1, 32'h500, 1'b0, 32'h0); sample(); tick();
        upd(32'h80, 1'b1, 32'h500, 1'b1, 32'h500); sample(); tick();
        upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h500); sample(); tick();
        drive(32'h40, 1'b1, 32'h80, 6'h20, 1'b1, 32'h500, 1'b0, 32'h0); sample();
        chk("gs_idx", 64'(pidx[1]), 64'h16);
        chk("bi_idx", 64'(pidx[0]), 64'h10);
        tick();
        look(32'h40); sample();
        chk("gs_idx_next", 64'(pidx[1]), 64'h1d);
        tick();

        // Stats then reset with a colliding update
        do_reset();
        for (int i = 0; i < 10; i++) begin
            upd(32'h80 + 32'(i * 4), i[0], 32'h600, (i < 3) ? !i[0] : i[0], 32'h600);
            sample(); tick();
        end
        look(32'h40); sample();
        chk("stat_br10", 64'(sbr[0]), 64'd10);
        chk("stat_mp3", 64'(smp[0]), 64'd3);
        tick();
        reset = 1'b1; upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); sample(); tick(); reset = 1'b0;
        look(32'h40); sample();
        chk("rst_stat_br", 64'(sbr[0]), 64'd0);
        chk("rst_stat_mp", 64'(smp[0]), 64'd0);
        chk("rst_hit40", 64'(hit[0]), 64'h0);
        tick();
        upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0); sample(); tick();
        upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); sample(); tick();
        look(32'h40); sample();
        chk("rst_pht_kept", 64'(tk[0]), 64'h0);
        chk("rst_hit_after", 64'(hit[0]), 64'h1);
        tick();

        // Randomised traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            logic [31:0] up, tg;
            logic t;
            up = rnd_pc();
            t  = 1'($urandom_range(0, 1));
            tg = ($urandom_range(0, 1) == 1) ? 32'h700 : ($urandom & 32'hFFFC);
            drive(rnd_pc(), 1'($urandom_range(0, 3) != 0), up, 6'($urandom_range(0, 63)), t, tg,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? tg : 32'h700);
            reset = ($urandom_range(0, 49) == 0);
            sample(); tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
